// File: rtl/speed_seq_pkg.sv
// Shared types and helpers for the speed sequencer: FSM states, speed codes,
// schedule entry layout and the speed-code-to-period mapping.
package speed_seq_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN,
        DONE
    } state_t;

    localparam logic [1:0] SPEED_FULL    = 2'b00;
    localparam logic [1:0] SPEED_BASE    = 2'b01;
    localparam logic [1:0] SPEED_HALF    = 2'b10;
    localparam logic [1:0] SPEED_QUARTER = 2'b11;

    typedef struct packed {
        logic [1:0] speed;
        logic [3:0] count;
    } step_t;

    function automatic int unsigned period(input logic [1:0] speed,
                                           input int unsigned clock_frequency);
        case (speed)
            SPEED_FULL:    period = 1;
            SPEED_BASE:    period = clock_frequency;
            SPEED_HALF:    period = 2 * clock_frequency;
            SPEED_QUARTER: period = 4 * clock_frequency;
            default:       period = 1;
        endcase
    endfunction

endpackage

// File: rtl/rate_tick.sv
// Loadable down-counter: ticks when it reaches zero, then reloads the value
// captured by the most recent Load.
module rate_tick #(
    parameter int unsigned WIDTH = 12
) (
    input  logic             ClockIn,
    input  logic             Reset,
    input  logic             Load,
    input  logic [WIDTH-1:0] LoadValue,
    output logic             Pulse
);

    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] r_reload;

    assign Pulse = (r_count == '0);

    always_ff @(posedge ClockIn) begin
        if (Reset) begin
            r_count  <= '0;
            r_reload <= '0;
        end else if (Load) begin
            r_count  <= LoadValue;
            r_reload <= LoadValue;
        end else if (Pulse) begin
            r_count  <= r_reload;
        end else begin
            r_count  <= r_count - 1'b1;
        end
    end

endmodule

// File: rtl/speed_sequencer.sv
// Runs a small (speed, pulse count) schedule through a loadable rate divider
// and counts emitted pulses on a 4-bit display counter.
module speed_sequencer
    import speed_seq_pkg::*;
#(
    parameter int unsigned CLOCK_FREQUENCY = 500,
    parameter int unsigned NUM_STEPS       = 4
) (
    input  logic                         ClockIn,
    input  logic                         Reset,
    input  logic                         Start,
    input  logic                         Abort,
    input  logic                         WrEn,
    input  logic [$clog2(NUM_STEPS)-1:0] WrAddr,
    input  logic [1:0]                   WrSpeed,
    input  logic [3:0]                   WrCount,
    output logic                         Pulse,
    output logic [3:0]                   CounterValue,
    output logic [$clog2(NUM_STEPS)-1:0] Step,
    output logic                         Busy,
    output logic                         Done
);

    localparam int unsigned    SW        = $clog2(NUM_STEPS);
    localparam int unsigned    DW        = $clog2(4 * CLOCK_FREQUENCY) + 1;
    localparam logic [SW-1:0]  LAST_STEP = SW'(NUM_STEPS - 1);

    state_t          r_state;
    state_t          w_next_state;
    step_t           r_table [NUM_STEPS];
    logic [SW-1:0]   r_step;
    logic [3:0]      r_remaining;
    logic [3:0]      r_counter;

    step_t           w_entry;
    logic [DW-1:0]   w_load_value;
    logic            w_tick;
    logic            w_pulse;
    logic            w_div_load;
    logic            w_table_we;
    logic            w_step_zero;
    logic            w_step_inc;
    logic            w_load_remaining;
    logic            w_clear_counter;

    assign w_entry      = r_table[r_step];
    assign w_load_value = DW'(period(w_entry.speed, CLOCK_FREQUENCY) - 1);

    rate_tick #(
        .WIDTH(DW)
    ) u_rate_tick (
        .ClockIn  (ClockIn),
        .Reset    (Reset),
        .Load     (w_div_load),
        .LoadValue(w_load_value),
        .Pulse    (w_tick)
    );

    always_ff @(posedge ClockIn) begin
        if (Reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state     = r_state;
        w_pulse          = 1'b0;
        w_div_load       = 1'b0;
        w_table_we       = 1'b0;
        w_step_zero      = 1'b0;
        w_step_inc       = 1'b0;
        w_load_remaining = 1'b0;
        w_clear_counter  = 1'b0;
        Busy             = 1'b0;
        Done             = 1'b0;

        case (r_state)
            IDLE: begin
                w_table_we = WrEn;
                if (Start && !Abort) begin
                    w_next_state    = LOAD;
                    w_step_zero     = 1'b1;
                    w_clear_counter = 1'b1;
                end
            end
            LOAD: begin
                Busy = 1'b1;
                if (w_entry.count == '0) begin
                    if (r_step == LAST_STEP) begin
                        w_next_state = DONE;
                    end else begin
                        w_step_inc = 1'b1;
                    end
                end else begin
                    w_div_load       = 1'b1;
                    w_load_remaining = 1'b1;
                    w_next_state     = RUN;
                end
            end
            RUN: begin
                Busy    = 1'b1;
                w_pulse = w_tick;
                if (w_tick && (r_remaining == 4'd1)) begin
                    if (r_step == LAST_STEP) begin
                        w_next_state = DONE;
                    end else begin
                        w_next_state = LOAD;
                        w_step_inc   = 1'b1;
                    end
                end
            end
            DONE: begin
                Done         = 1'b1;
                w_next_state = IDLE;
                w_step_zero  = 1'b1;
            end
            default: w_next_state = IDLE;
        endcase

        // Abort overrides sequencing but not the counter update from a same-cycle pulse
        if (Abort && (r_state != IDLE)) begin
            w_next_state = IDLE;
            w_step_zero  = 1'b1;
            w_step_inc   = 1'b0;
        end
    end

    always_ff @(posedge ClockIn) begin
        if (Reset) begin
            r_step      <= '0;
            r_remaining <= '0;
            r_counter   <= '0;
            for (int unsigned i = 0; i < NUM_STEPS; i++) begin
                r_table[i] <= '0;
            end
        end else begin
            if (w_table_we) begin
                r_table[WrAddr] <= step_t'{speed: WrSpeed, count: WrCount};
            end

            if (w_step_zero) begin
                r_step <= '0;
            end else if (w_step_inc) begin
                r_step <= r_step + 1'b1;
            end

            if (w_load_remaining) begin
                r_remaining <= w_entry.count;
            end else if (w_pulse) begin
                r_remaining <= r_remaining - 1'b1;
            end

            if (w_clear_counter) begin
                r_counter <= '0;
            end else if (w_pulse) begin
                r_counter <= r_counter + 1'b1;
            end
        end
    end

    assign Pulse        = w_pulse;
    assign CounterValue = r_counter;
    assign Step         = r_step;

endmodule

// File: tb/tb_speed_sequencer.sv
// Directed bench for speed_sequencer: a per-cycle vector table for the main
// schedule run plus hand-written sequences for skip, wrap, abort and reset.
module tb_speed_sequencer;

    logic       ClockIn;
    logic       Reset;
    logic       Start;
    logic       Abort;
    logic       WrEn;
    logic [1:0] WrAddr;
    logic [1:0] WrSpeed;
    logic [3:0] WrCount;
    logic       Pulse;
    logic [3:0] CounterValue;
    logic [1:0] Step;
    logic       Busy;
    logic       Done;

    int checks   = 0;
    int failures = 0;

    speed_sequencer #(
        .CLOCK_FREQUENCY(4),
        .NUM_STEPS      (4)
    ) dut (
        .ClockIn     (ClockIn),
        .Reset       (Reset),
        .Start       (Start),
        .Abort       (Abort),
        .WrEn        (WrEn),
        .WrAddr      (WrAddr),
        .WrSpeed     (WrSpeed),
        .WrCount     (WrCount),
        .Pulse       (Pulse),
        .CounterValue(CounterValue),
        .Step        (Step),
        .Busy        (Busy),
        .Done        (Done)
    );

    initial begin
        ClockIn = 1'b0;
        forever #5 ClockIn = ~ClockIn;
    end

    // Each record: inputs held for reps cycles; exp = {Pulse, CounterValue, Step, Busy, Done}
    // observed after every one of those edges.
    typedef struct packed {
        logic       start;
        logic       abort;
        logic       wr_en;
        logic [1:0] wr_addr;
        logic [1:0] wr_speed;
        logic [3:0] wr_count;
        logic [7:0] reps;
        logic [8:0] exp;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [8:0] pk(input logic p, input logic [3:0] cv,
                                      input logic [1:0] s, input logic b, input logic d);
        return {p, cv, s, b, d};
    endfunction

    function automatic vec_t mk(input logic st, input logic ab, input logic we,
                                input logic [1:0] a, input logic [1:0] sp, input logic [3:0] c,
                                input int unsigned n, input logic p, input logic [3:0] cv,
                                input logic [1:0] s, input logic b, input logic d);
        vec_t v;
        v.start    = st;
        v.abort    = ab;
        v.wr_en    = we;
        v.wr_addr  = a;
        v.wr_speed = sp;
        v.wr_count = c;
        v.reps     = 8'(n);
        v.exp      = pk(p, cv, s, b, d);
        return v;
    endfunction

    function automatic logic [8:0] obs();
        return {Pulse, CounterValue, Step, Busy, Done};
    endfunction

    task automatic cyc();
        @(posedge ClockIn);
        @(negedge ClockIn);
    endtask

    task automatic chk(input string name, input logic [8:0] act, input logic [8:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got p=%b cnt=%0d step=%0d busy=%b done=%b want p=%b cnt=%0d step=%0d busy=%b done=%b",
                     name, act[8], act[7:4], act[3:2], act[1], act[0],
                     exp[8], exp[7:4], exp[3:2], exp[1], exp[0]);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        Start   = 1'b0;
        Abort   = 1'b0;
        WrEn    = 1'b0;
        WrAddr  = '0;
        WrSpeed = '0;
        WrCount = '0;
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        cyc();
        Reset = 1'b0;
    endtask

    task automatic wr(input logic [1:0] a, input logic [1:0] sp, input logic [3:0] c);
        WrEn    = 1'b1;
        WrAddr  = a;
        WrSpeed = sp;
        WrCount = c;
        cyc();
        clear_inputs();
    endtask

    // Every entry has count 0: four LOAD cycles, then Done, no pulses.
    task automatic run_all_skip(input string tag);
        Start = 1'b1;
        cyc();
        Start = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            chk($sformatf("%s_load%0d", tag, k), obs(), pk(1'b0, 4'd0, 2'(k - 1), 1'b1, 1'b0));
            cyc();
        end
        chk($sformatf("%s_done", tag), obs(), pk(1'b0, 4'd0, 2'd3, 1'b0, 1'b1));
        cyc();
        chk($sformatf("%s_idle", tag), obs(), pk(1'b0, 4'd0, 2'd0, 1'b0, 1'b0));
    endtask

    initial begin
        int npulse;

        clear_inputs();
        Reset = 1'b1;
        @(negedge ClockIn);
        cyc();
        cyc();
        Reset = 1'b0;
        chk("reset_state", obs(), pk(1'b0, 4'd0, 2'd0, 1'b0, 1'b0));

        // Schedule {01/2, 00/3, 00/0, 10/1} with CLOCK_FREQUENCY=4, Start applied in row 5.
        vecs.push_back(mk(0, 0, 1, 2'd0, 2'b01, 4'd2, 1, 0, 4'd0, 2'd0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 2'd1, 2'b00, 4'd3, 1, 0, 4'd0, 2'd0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 2'd2, 2'b00, 4'd0, 1, 0, 4'd0, 2'd0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 2'd3, 2'b10, 4'd1, 1, 0, 4'd0, 2'd0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 2'd0, 2'b00, 4'd0, 1, 0, 4'd0, 2'd0, 1, 0)); // t+1 LOAD
        vecs.push_back(mk(0, 0, 0, 2'd0, 2'b00, 4'd0, 3, 0, 4'd0, 2'd0, 1, 0)); // t+2..4
        vecs.push_back(mk(0, 0, 0, 2'd0, 2'b00, 4'd0, 1, 1, 4'd0, 2'd0, 1, 0)); // t+5 pulse
        vecs.push_back(mk(0, 0, 0, 2'd0, 2'b00, 4'd0, 3, 0, 4'd1, 2'd0, 1, 0)); // t+6..8
        vecs.push_back(mk(0, 0, 0, 2'd0, 2'b00, 4'd0, 1, 1, 4'd1, 2'd0, 1, 0)); // t+9 pulse
        vecs.push_back(mk(0, 0, 0, 2'd0, 2'b00, 4'd0, 1, 0, 4'd2, 2'd1, 1, 0)); // t+10 LOAD
        vecs.push_back(mk(0, 0, 0, 2'd0, 2'b00, 4'd0, 1, 1, 4'd2, 2'd1, 1, 0)); // t+11
        vecs.push_back(mk(0, 0, 0, 2'd0, 2'b00, 4'd0, 1, 1, 4'd3, 2'd1, 1, 0)); // t+12
        vecs.push_back(mk(0, 0, 0, 2'd0, 2'b00, 4'd0, 1, 1, 4'd4, 2'd1, 1, 0)); // t+13
        vecs.push_back(mk(0, 0, 0, 2'd0, 2'b00, 4'd0, 1, 0, 4'd5, 2'd2, 1, 0)); // t+14 skip
        vecs.push_back(mk(0, 0, 0, 2'd0, 2'b00, 4'd0, 1, 0, 4'd5, 2'd3, 1, 0)); // t+15 LOAD
        vecs.push_back(mk(0, 0, 0, 2'd0, 2'b00, 4'd0, 7, 0, 4'd5, 2'd3, 1, 0)); // t+16..22
        vecs.push_back(mk(0, 0, 0, 2'd0, 2'b00, 4'd0, 1, 1, 4'd5, 2'd3, 1, 0)); // t+23 pulse
        vecs.push_back(mk(0, 0, 0, 2'd0, 2'b00, 4'd0, 1, 0, 4'd6, 2'd3, 0, 1)); // t+24 DONE
        vecs.push_back(mk(0, 0, 0, 2'd0, 2'b00, 4'd0, 2, 0, 4'd6, 2'd0, 0, 0));
        // Start together with Abort in IDLE: no run, counter holds.
        vecs.push_back(mk(1, 1, 0, 2'd0, 2'b00, 4'd0, 1, 0, 4'd6, 2'd0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 2'd0, 2'b00, 4'd0, 2, 0, 4'd6, 2'd0, 0, 0));
        // Write entry 0 to 00/1 on the Start edge, then Abort on the pulse cycle.
        vecs.push_back(mk(1, 0, 1, 2'd0, 2'b00, 4'd1, 1, 0, 4'd0, 2'd0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 2'd0, 2'b00, 4'd0, 1, 1, 4'd0, 2'd0, 1, 0));
        vecs.push_back(mk(0, 1, 0, 2'd0, 2'b00, 4'd0, 1, 0, 4'd1, 2'd0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 2'd0, 2'b00, 4'd0, 1, 0, 4'd1, 2'd0, 0, 0));

        foreach (vecs[i]) begin
            Start   = vecs[i].start;
            Abort   = vecs[i].abort;
            WrEn    = vecs[i].wr_en;
            WrAddr  = vecs[i].wr_addr;
            WrSpeed = vecs[i].wr_speed;
            WrCount = vecs[i].wr_count;
            for (int unsigned r = 0; r < vecs[i].reps; r++) begin
                cyc();
                chk($sformatf("vec%0d.%0d", i, r), obs(), vecs[i].exp);
            end
        end
        clear_inputs();

        // All counts zero after reset.
        do_reset();
        run_all_skip("skip_all");

        // Wrap: 00/15, 00/15, 00/2, 00/0 -> 32 pulses, counter ends at 0.
        do_reset();
        wr(2'd0, 2'b00, 4'd15);
        wr(2'd1, 2'b00, 4'd15);
        wr(2'd2, 2'b00, 4'd2);
        Start = 1'b1;
        cyc();
        Start = 1'b0;
        npulse = 0;
        for (int k = 1; k <= 36; k++) begin
            if (Pulse === 1'b1) npulse++;
            case (k)
                1:  chk("wrap_k1",  obs(), pk(1'b0, 4'd0,  2'd0, 1'b1, 1'b0));
                17: chk("wrap_k17", obs(), pk(1'b0, 4'd15, 2'd1, 1'b1, 1'b0));
                19: chk("wrap_k19", obs(), pk(1'b1, 4'd0,  2'd1, 1'b1, 1'b0));
                33: chk("wrap_k33", obs(), pk(1'b0, 4'd14, 2'd2, 1'b1, 1'b0));
                36: chk("wrap_k36", obs(), pk(1'b0, 4'd0,  2'd3, 1'b1, 1'b0));
                default: ;
            endcase
            cyc();
        end
        chk_int("wrap_pulses", npulse, 32);
        chk("wrap_done", obs(), pk(1'b0, 4'd0, 2'd3, 1'b0, 1'b1));

        // Abort in step 1 after 3 pulses; WrEn to entry 3 during RUN is ignored.
        do_reset();
        wr(2'd0, 2'b00, 4'd2);
        wr(2'd1, 2'b01, 4'd5);
        Start = 1'b1;
        cyc();
        Start = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            case (k)
                8:  chk("abort_k8",  obs(), pk(1'b1, 4'd2, 2'd1, 1'b1, 1'b0));
                12: chk("abort_k12", obs(), pk(1'b1, 4'd3, 2'd1, 1'b1, 1'b0));
                16: chk("abort_k16", obs(), pk(1'b1, 4'd4, 2'd1, 1'b1, 1'b0));
                default: ;
            endcase
            if (k == 9) begin
                WrEn    = 1'b1;
                WrAddr  = 2'd3;
                WrSpeed = 2'b00;
                WrCount = 4'd7;
            end else if (k == 10) begin
                clear_inputs();
            end
            cyc();
        end
        chk("abort_before", obs(), pk(1'b0, 4'd5, 2'd1, 1'b1, 1'b0));
        Abort = 1'b1;
        cyc();
        Abort = 1'b0;
        chk("abort_after", obs(), pk(1'b0, 4'd5, 2'd0, 1'b0, 1'b0));
        wr(2'd0, 2'b00, 4'd0);
        wr(2'd1, 2'b00, 4'd0);
        run_all_skip("wr_ignored");

        // Reset mid-RUN overrides Abort, Start and WrEn; table is cleared.
        wr(2'd0, 2'b00, 4'd15);
        Start = 1'b1;
        cyc();
        Start = 1'b0;
        cyc();
        cyc();
        chk("rst_run_before", obs(), pk(1'b1, 4'd1, 2'd0, 1'b1, 1'b0));
        Reset   = 1'b1;
        Abort   = 1'b1;
        Start   = 1'b1;
        WrEn    = 1'b1;
        WrAddr  = 2'd3;
        WrSpeed = 2'b00;
        WrCount = 4'd7;
        cyc();
        Reset = 1'b0;
        clear_inputs();
        chk("rst_run_after", obs(), pk(1'b0, 4'd0, 2'd0, 1'b0, 1'b0));
        run_all_skip("rst_cleared");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
